// File: rtl/raw_mb_fetch.sv
// Raw MB pixel fetch: walks a frame in MB raster order over a 64-bit luma + NV12 chroma memory.
// Latency: first word >= 2 cycles after frame_start_i; backpressure: pinc_i low stalls output, fetch runs on credits.

// Generic single-clock FIFO, power-of-two depth.
// Latency: a pushed word appears at head_dat the cycle after the push.
// Backpressure: none internally; the caller guarantees no push when full and no pop when empty.
module raw_mb_fetch_fifo #(
   parameter int W     = 64,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push_vld,
   input  logic [W-1:0]           push_dat,
   input  logic                   pop_vld,
   output logic [W-1:0]           head_dat,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] cnt
);
   localparam int PTRW = $clog2(DEPTH);

   logic [W-1:0]    mem [DEPTH];
   logic [PTRW-1:0] wr_ptr;
   logic [PTRW-1:0] rd_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push_vld) begin
            mem[wr_ptr] <= push_dat;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop_vld) rd_ptr <= rd_ptr + 1'b1;
         case ({push_vld, pop_vld})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   assign head_dat = mem[rd_ptr];
   assign empty    = (cnt == '0);
endmodule

// Frame-side pixel source: 48 words per MB (32 luma, 16 interleaved UV), MB raster order.
// Latency: memory latency plus one FIFO stage; prefetch continues across MB boundaries.
// Backpressure: pinc_i low stalls pvalid_o; reads stop once FIFO occupancy + outstanding reaches FIFO_DEPTH.
module raw_mb_fetch #(
   parameter int BIT_DEPTH  = 8,
   parameter int AW         = 20,
   parameter int MBW        = 7,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   frame_start_i,
   input  logic [MBW-1:0]         pic_w_mb_i,
   input  logic [MBW-1:0]         pic_h_mb_i,
   input  logic [AW-1:0]          y_base_i,
   input  logic [AW-1:0]          uv_base_i,
   output logic                   busy_o,
   output logic                   frame_done_o,
   output logic [MBW-1:0]         mb_x_o,
   output logic [MBW-1:0]         mb_y_o,
   input  logic                   pinc_i,
   output logic                   pvalid_o,
   output logic [8*BIT_DEPTH-1:0] pdata_o,
   output logic                   mem_req_o,
   output logic [AW-1:0]          mem_addr_o,
   input  logic                   mem_gnt_i,
   input  logic                   mem_rvalid_i,
   input  logic [63:0]            mem_rdata_i
);
   localparam int PW = 8 * BIT_DEPTH;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [5:0]     K_LUMA_LAST = 6'd31;
   localparam logic [5:0]     K_LAST      = 6'd47;
   localparam logic [MBW-1:0] MB_ONE      = MBW'(1);
   localparam logic [CW:0]    DEPTH_C     = (CW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;
   state_t state_q, state_d;

   logic [MBW-1:0] w_q, h_q;
   logic [AW-1:0]  stride_q;
   logic [AW-1:0]  y_row_q;     // luma address of line 0 of the current request MB row
   logic [AW-1:0]  uv_row_q;    // chroma address of line 0 of the current request MB row
   logic [AW-1:0]  col_q;       // 2*mb_x of the request cursor
   logic [AW-1:0]  addr_q;
   logic [AW-1:0]  addr_nx;
   logic [5:0]     rq_k;
   logic [MBW-1:0] rq_x, rq_y;
   logic [5:0]     tx_k;
   logic [MBW-1:0] mb_x_q, mb_y_q;
   logic [CW-1:0]  outst_q;
   logic           done_q;

   logic           start, zero_dim, gnt, acc, credit_ok;
   logic           rq_x_last, rq_last, rq_k_last, tx_last;
   logic [CW-1:0]  fifo_cnt;
   logic           fifo_empty;
   logic [PW-1:0]  push_dat;
   logic [PW-1:0]  head_dat;

   assign start     = frame_start_i & (state_q == S_IDLE);
   assign zero_dim  = (pic_w_mb_i == '0) | (pic_h_mb_i == '0);
   assign gnt       = mem_req_o & mem_gnt_i;
   assign acc       = mem_rvalid_i & (outst_q != '0);
   assign credit_ok = ({1'b0, fifo_cnt} + {1'b0, outst_q}) < DEPTH_C;
   assign rq_x_last = (rq_x == w_q - MB_ONE);
   assign rq_last   = rq_x_last & (rq_y == h_q - MB_ONE);
   assign rq_k_last = (rq_k == K_LAST);
   assign tx_last   = (tx_k == K_LAST) & (mb_x_q == w_q - MB_ONE) & (mb_y_q == h_q - MB_ONE);
   assign pvalid_o  = pinc_i & ~fifo_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      mem_req_o = 1'b0;
      busy_o    = 1'b1;
      case (state_q)
         S_IDLE: begin
            busy_o = 1'b0;
            if (start & ~zero_dim) state_d = S_FETCH;
         end
         S_FETCH: begin
            mem_req_o = credit_ok;
            if (credit_ok & mem_gnt_i & rq_k_last & rq_last) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (pvalid_o & tx_last) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Words alternate left/right half of a 16-px line; odd words step down one line.
   always_comb begin
      addr_nx = addr_q + AW'(1);
      if (rq_k_last)
         addr_nx = rq_x_last ? (y_row_q + (stride_q << 4)) : (y_row_q + col_q + AW'(2));
      else if (rq_k == K_LUMA_LAST)
         addr_nx = uv_row_q + col_q;
      else if (rq_k[0])
         addr_nx = addr_q + stride_q - AW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_q      <= '0;
         h_q      <= '0;
         stride_q <= '0;
         y_row_q  <= '0;
         uv_row_q <= '0;
         col_q    <= '0;
         addr_q   <= '0;
         rq_k     <= '0;
         rq_x     <= '0;
         rq_y     <= '0;
      end else if (start) begin
         w_q      <= pic_w_mb_i;
         h_q      <= pic_h_mb_i;
         stride_q <= AW'(pic_w_mb_i) << 1;
         y_row_q  <= y_base_i;
         uv_row_q <= uv_base_i;
         col_q    <= '0;
         addr_q   <= y_base_i;
         rq_k     <= '0;
         rq_x     <= '0;
         rq_y     <= '0;
      end else if (gnt) begin
         addr_q <= addr_nx;
         if (rq_k_last) begin
            rq_k <= '0;
            if (rq_x_last) begin
               rq_x     <= '0;
               rq_y     <= rq_y + MB_ONE;
               y_row_q  <= y_row_q + (stride_q << 4);
               uv_row_q <= uv_row_q + (stride_q << 3);
               col_q    <= '0;
            end else begin
               rq_x  <= rq_x + MB_ONE;
               col_q <= col_q + AW'(2);
            end
         end else begin
            rq_k <= rq_k + 6'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_k    <= '0;
         mb_x_q  <= '0;
         mb_y_q  <= '0;
         outst_q <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= (start & zero_dim) | ((state_q == S_DRAIN) & pvalid_o & tx_last);
         case ({gnt, acc})
            2'b10:   outst_q <= outst_q + 1'b1;
            2'b01:   outst_q <= outst_q - 1'b1;
            default: outst_q <= outst_q;
         endcase
         if (start) begin
            tx_k   <= '0;
            mb_x_q <= '0;
            mb_y_q <= '0;
         end else if (pvalid_o) begin
            if (tx_k == K_LAST) begin
               tx_k <= '0;
               if (tx_last) begin
                  mb_x_q <= '0;
                  mb_y_q <= '0;
               end else if (mb_x_q == w_q - MB_ONE) begin
                  mb_x_q <= '0;
                  mb_y_q <= mb_y_q + MB_ONE;
               end else begin
                  mb_x_q <= mb_x_q + MB_ONE;
               end
            end else begin
               tx_k <= tx_k + 6'd1;
            end
         end
      end
   end

   // Memory bytes are 8-bit pixels; widen each into its BIT_DEPTH slot, order preserved.
   for (genvar j = 0; j < 8; j++) begin : g_pix
      assign push_dat[j*BIT_DEPTH +: BIT_DEPTH] = BIT_DEPTH'(mem_rdata_i[j*8 +: 8]);
   end

   raw_mb_fetch_fifo #(.W(PW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push_vld (acc),
      .push_dat (push_dat),
      .pop_vld  (pvalid_o),
      .head_dat (head_dat),
      .empty    (fifo_empty),
      .cnt      (fifo_cnt)
   );

   assign pdata_o      = head_dat;
   assign mb_x_o       = mb_x_q;
   assign mb_y_o       = mb_y_q;
   assign mem_addr_o   = addr_q;
   assign frame_done_o = done_q;
endmodule

// File: tb/tb_raw_mb_fetch.sv
// Randomized scoreboard bench for raw_mb_fetch: address and pixel streams checked against a frame-walk model.
module tb_raw_mb_fetch;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        frame_start_i;
   logic [6:0]  pic_w_mb_i, pic_h_mb_i;
   logic [19:0] y_base_i, uv_base_i;
   logic        busy_o, frame_done_o;
   logic [6:0]  mb_x_o, mb_y_o;
   logic        pinc_i;
   logic        pvalid_o;
   logic [63:0] pdata_o;
   logic        mem_req_o;
   logic [19:0] mem_addr_o;
   logic        mem_gnt_i, mem_rvalid_i;
   logic [63:0] mem_rdata_i;

   raw_mb_fetch dut (
      .clk(clk), .rst_n(rst_n), .frame_start_i(frame_start_i),
      .pic_w_mb_i(pic_w_mb_i), .pic_h_mb_i(pic_h_mb_i),
      .y_base_i(y_base_i), .uv_base_i(uv_base_i),
      .busy_o(busy_o), .frame_done_o(frame_done_o),
      .mb_x_o(mb_x_o), .mb_y_o(mb_y_o),
      .pinc_i(pinc_i), .pvalid_o(pvalid_o), .pdata_o(pdata_o),
      .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
   );

   always #5 clk = ~clk;

   typedef struct {logic [63:0] d; int x; int y;} exp_t;
   typedef struct {logic [19:0] a; int due;} ret_t;

   exp_t        exp_q[$];
   logic [19:0] addr_q[$];
   ret_t        ret_q[$];
   int          errs = 0, checks = 0;
   int          cyc = 0;
   int          granted = 0, popped = 0, frame_pops = 0;
   int          gnt_mode = 0, lat_min = 1, lat_max = 1, pinc_mode = 0;
   logic        done_due = 1'b0, done_due_next = 1'b0;
   logic        req_hold = 1'b0;
   logic [19:0] held_addr = '0;
   logic        first_pending = 1'b0;
   logic [19:0] first_gnt_addr = '0;

   function automatic logic [63:0] memw(input logic [19:0] a);
      return {12'hABC, a, ~a, 12'h5A5};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: every word's address straight from the MB geometry, in stream order.
   task automatic build_model(input int w, input int h, input logic [19:0] yb, input logic [19:0] uvb);
      logic [19:0] a;
      exp_t        e;
      int          s;
      s = 2 * w;
      for (int my = 0; my < h; my++)
         for (int mx = 0; mx < w; mx++)
            for (int k = 0; k < 48; k++) begin
               if (k < 32) a = yb + 20'((16*my + k/2) * s + 2*mx + k%2);
               else        a = uvb + 20'((8*my + (k-32)/2) * s + 2*mx + (k-32)%2);
               addr_q.push_back(a);
               e.d = memw(a); e.x = mx; e.y = my;
               exp_q.push_back(e);
            end
   endtask

   // Memory: random grants, in-order returns after a random latency.
   initial begin
      ret_t r;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) ret_q.delete();
         else if (mem_req_o && mem_gnt_i) begin
            r.a = mem_addr_o;
            r.due = cyc + int'($urandom_range(lat_max, lat_min));
            ret_q.push_back(r);
         end
         @(posedge clk);
         cyc++;
         #1;
         mem_gnt_i = (gnt_mode == 0) ? 1'b1 : 1'($urandom % 2);
         if (rst_n && ret_q.size() > 0 && ret_q[0].due <= cyc) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = memw(ret_q[0].a);
            void'(ret_q.pop_front());
         end else begin
            mem_rvalid_i = 1'b0;
         end
      end
   end

   initial begin
      pinc_i = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (pinc_mode)
            0:       pinc_i = 1'b1;
            1:       pinc_i = ($urandom_range(9, 0) < 8);
            default: pinc_i = 1'b0;
         endcase
      end
   end

   // Monitor / scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            exp_q.delete(); addr_q.delete();
            done_due = 1'b0; done_due_next = 1'b0; req_hold = 1'b0;
            granted = 0; popped = 0; first_pending = 1'b0;
         end else begin
            if (done_due || frame_done_o) begin
               chk("frame_done", 64'(frame_done_o), 64'(done_due));
               if (done_due) chk("busy_at_done", 64'(busy_o), 64'd0);
            end
            done_due = 1'b0;
            if (frame_start_i && !busy_o) begin
               if (pic_w_mb_i == 0 || pic_h_mb_i == 0) done_due_next = 1'b1;
               else begin
                  build_model(int'(pic_w_mb_i), int'(pic_h_mb_i), y_base_i, uv_base_i);
                  granted = 0; popped = 0; frame_pops = 0; first_pending = 1'b1;
               end
            end
            if (req_hold) chk("req_held", {43'd0, mem_req_o, mem_addr_o}, {43'd0, 1'b1, held_addr});
            req_hold  = mem_req_o && !mem_gnt_i;
            held_addr = mem_addr_o;
            if (mem_req_o && mem_gnt_i) begin
               granted++;
               if (first_pending) begin first_gnt_addr = mem_addr_o; first_pending = 1'b0; end
               if (addr_q.size() == 0) begin
                  checks++; errs++;
                  $display("FAIL unexpected_req: addr %h, expected no request", mem_addr_o);
               end else chk("req_addr", 64'(mem_addr_o), 64'(addr_q.pop_front()));
            end
            if (pvalid_o) begin
               popped++; frame_pops++;
               if (exp_q.size() == 0) begin
                  checks++; errs++;
                  $display("FAIL unexpected_pvalid: data %h, expected none", pdata_o);
               end else begin
                  e = exp_q.pop_front();
                  chk("pdata", pdata_o, e.d);
                  chk("mb_xy", 64'({mb_x_o, mb_y_o}), 64'({7'(e.x), 7'(e.y)}));
                  if (exp_q.size() == 0) done_due_next = 1'b1;
               end
            end
            if (busy_o) chk("credit", 64'(granted - popped <= 4), 64'd1);
            done_due = done_due_next;
            done_due_next = 1'b0;
         end
      end
   end

   task automatic chk_reset(input string tag);
      chk({tag, "_busy"},  64'(busy_o), 64'd0);
      chk({tag, "_done"},  64'(frame_done_o), 64'd0);
      chk({tag, "_pvalid"}, 64'(pvalid_o), 64'd0);
      chk({tag, "_req"},   64'(mem_req_o), 64'd0);
      chk({tag, "_mbxy"},  64'({mb_x_o, mb_y_o}), 64'd0);
      chk({tag, "_addr"},  64'(mem_addr_o), 64'd0);
      chk({tag, "_pdata"}, pdata_o, 64'd0);
   endtask

   task automatic start_frame(input int w, input int h, input logic [19:0] yb, input logic [19:0] uvb);
      @(posedge clk); #1;
      pic_w_mb_i = 7'(w); pic_h_mb_i = 7'(h); y_base_i = yb; uv_base_i = uvb;
      frame_start_i = 1'b1;
      @(posedge clk); #1;
      frame_start_i = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (busy_o && n < 20000) begin @(negedge clk); n++; end
      chk({name, "_timeout"}, 64'(busy_o), 64'd0);
      repeat (2) @(negedge clk);
      chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic wait_pops(input int target);
      int n;
      n = 0;
      while (frame_pops < target && n < 5000) begin @(negedge clk); n++; end
      chk("pops_reached", 64'(frame_pops >= target), 64'd1);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [19:0] yb, uvb;
      rst_n = 1'b0; frame_start_i = 1'b0;
      pic_w_mb_i = '0; pic_h_mb_i = '0; y_base_i = '0; uv_base_i = '0;
      repeat (3) @(negedge clk);
      chk_reset("rst");
      @(posedge clk); #1; rst_n = 1'b1;

      // 1x1 frame, fixed latency 2
      gnt_mode = 0; lat_min = 2; lat_max = 2; pinc_mode = 0;
      start_frame(1, 1, 20'h0, 20'h100);
      wait_idle("t1");
      chk("t1_pvalid_count", 64'(frame_pops), 64'd48);
      chk("t1_first_addr", 64'(first_gnt_addr), 64'h0);

      // 3x2 frame, random bases
      lat_min = 1; lat_max = 3;
      yb = 20'($urandom); uvb = 20'($urandom);
      start_frame(3, 2, yb, uvb);
      wait_idle("t2");
      chk("t2_pvalid_count", 64'(frame_pops), 64'd288);

      // consumer stall mid-MB
      start_frame(2, 1, 20'h4000, 20'h8000);
      wait_pops(20);
      pinc_mode = 2;
      repeat (20) @(negedge clk);
      chk("t3_req_stopped", 64'(mem_req_o), 64'd0);
      chk("t3_credits_full", 64'(granted - popped), 64'd4);
      pinc_mode = 0;
      wait_idle("t3");

      // random grants, latency 1..6, random consumer
      gnt_mode = 1; lat_min = 1; lat_max = 6; pinc_mode = 1;
      yb = 20'($urandom); uvb = 20'($urandom);
      start_frame(4, 3, yb, uvb);
      wait_idle("t4");
      chk("t4_pvalid_count", 64'(frame_pops), 64'd576);

      // reset mid-frame, then a clean restart
      gnt_mode = 0; lat_min = 1; lat_max = 3; pinc_mode = 0;
      start_frame(2, 2, 20'h2000, 20'h9000);
      wait_pops(68);
      @(posedge clk); #3; rst_n = 1'b0;
      @(negedge clk);
      chk_reset("midrst");
      repeat (2) @(posedge clk);
      #1; rst_n = 1'b1;
      start_frame(1, 1, 20'h12345, 20'h54321);
      wait_idle("t5");
      chk("t5_first_addr", 64'(first_gnt_addr), 64'h12345);

      // start while busy is ignored; zero-size frames
      gnt_mode = 1; pinc_mode = 1;
      start_frame(2, 1, 20'h0300, 20'h0700);
      repeat (10) @(negedge clk);
      start_frame(1, 1, 20'hABCDE, 20'h11111);
      wait_idle("t6");
      chk("t6_pvalid_count", 64'(frame_pops), 64'd96);
      gnt_mode = 0;
      start_frame(0, 3, 20'h10, 20'h20);
      @(negedge clk);
      chk("t6_zw_done", 64'(frame_done_o), 64'd1);
      for (int i = 0; i < 3; i++) begin
         chk("t6_zw_noreq", 64'({busy_o, mem_req_o}), 64'd0);
         @(negedge clk);
      end
      start_frame(2, 0, 20'h10, 20'h20);
      @(negedge clk);
      chk("t6_zh_done", 64'(frame_done_o), 64'd1);
      chk("t6_zh_noreq", 64'({busy_o, mem_req_o}), 64'd0);
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
